// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the integer register file
// with pending scoreboard and sequential clear engine.
//   DATA_W_DEF / ADDR_W_DEF : default register width / index width
//   clrState_t              : clear engine states (IDLE, CLEAR)
//   ZERO_IDX                : hardwired-zero register index
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_IDX   = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clrState_t;

endpackage

// File: rtl/regfile_clear_fsm.sv
// regfile_clear_fsm: sequential clear engine. Walks indices 1..DEPTH-1,
// one per cycle, and asks the register file to zero each one. Index 0 is
// hardwired to zero and is skipped.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | file usable; writes and issues accepted; waits clrStart
//   CLEAR | zeroing regs[cnt] each cycle, cnt = 1..DEPTH-1
//
// Ports:
//   clk, rst_n : clock, async active-low reset
//   clrStart   : request a full clear (honoured only in IDLE)
//   clrGo      : start accepted this cycle (pending bits clear at the edge)
//   clrWe      : zero regs[clrIdx] at the next edge
//   clrIdx     : index being zeroed
//   clrBusy    : engine active
//   isIdle     : engine in IDLE (writes/issues allowed)
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clrStart,
  output logic              clrGo,
  output logic              clrWe,
  output logic [ADDR_W-1:0] clrIdx,
  output logic              clrBusy,
  output logic              isIdle
);

  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'((2 ** ADDR_W) - 1);

  clrState_t         state, nextState;
  logic [ADDR_W-1:0] cnt, nextCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
    end
  end

  // The counter saturates at LAST on exit; a new start reloads it.
  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    case (state)
      IDLE: begin
        if (clrStart) begin
          nextState = CLEAR;
          nextCnt   = FIRST;
        end
      end
      CLEAR: begin
        if (cnt == LAST) nextState = IDLE;
        else             nextCnt   = cnt + ADDR_W'(1);
      end
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    isIdle  = (state == IDLE);
    clrBusy = (state == CLEAR);
    clrWe   = (state == CLEAR);
    clrIdx  = cnt;
    clrGo   = (state == IDLE) && clrStart;
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: integer register file, 2 combinational read ports,
// 1 synchronous write port, x0 hardwired to zero, per-register pending
// scoreboard and a sequential clear engine.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   : same-cycle write-through forwarding on both read ports
//   undefined : reads return the registered contents only
//
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   we, waddr, wdata    : writeback write port
//   raddr1/2, rdata1/2  : combinational read ports
//   issue_valid/rd      : issued instruction marks its destination pending
//   rs1/rs2_pending     : pending bit of raddr1/raddr2
//   clr_start, clr_busy : full-file clear request / engine active
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              rs1_pending,
  output logic              rs2_pending,
  input  logic              clr_start,
  output logic              clr_busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(ZERO_IDX);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pending;

  logic              clrGo, clrWe, fsmIdle;
  logic [ADDR_W-1:0] clrIdx;
  logic              wrQual, issueQual;

  regfile_clear_fsm #(.ADDR_W(ADDR_W)) uClearFsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .clrStart (clr_start),
    .clrGo    (clrGo),
    .clrWe    (clrWe),
    .clrIdx   (clrIdx),
    .clrBusy  (clr_busy),
    .isIdle   (fsmIdle)
  );

  assign wrQual    = we && (waddr != ZERO) && fsmIdle;
  assign issueQual = issue_valid && (issue_rd != ZERO) && fsmIdle;

  // The clear engine and writeback are mutually exclusive (wrQual needs IDLE).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (clrWe) begin
      regs[clrIdx] <= '0;
    end else if (wrQual) begin
      regs[waddr] <= wdata;
    end
  end

  // Set is applied after clear so a same-index issue keeps the bit set:
  // the newer producer is still outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else if (clrGo) begin
      pending <= '0;
    end else begin
      if (wrQual)    pending[waddr]    <= 1'b0;
      if (issueQual) pending[issue_rd] <= 1'b1;
    end
  end

  always_comb begin
    rdata1      = (raddr1 == ZERO) ? '0 : regs[raddr1];
    rdata2      = (raddr2 == ZERO) ? '0 : regs[raddr2];
    rs1_pending = fsmIdle && pending[raddr1];
    rs2_pending = fsmIdle && pending[raddr2];
`ifdef REGFILE_BYPASS_EN
    // rst_n gate keeps the outputs at zero while reset is held.
    if (rst_n && wrQual && (raddr1 == waddr)) begin
      rdata1      = wdata;
      rs1_pending = issue_valid && (issue_rd == waddr);
    end
    if (rst_n && wrQual && (raddr2 == waddr)) begin
      rdata2      = wdata;
      rs2_pending = issue_valid && (issue_rd == waddr);
    end
`endif
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [4:0]  raddr1 = '0;
  logic [4:0]  raddr2 = '0;
  logic [31:0] rdata1, rdata2;
  logic        iv = 1'b0;
  logic [4:0]  issueRd = '0;
  logic        rs1P, rs2P;
  logic        clrStart = 1'b0;
  logic        busy;

  regfile_scoreboard dut (
    .clk         (clk),
    .rst_n       (rstN),
    .we          (we),
    .waddr       (waddr),
    .wdata       (wdata),
    .raddr1      (raddr1),
    .raddr2      (raddr2),
    .rdata1      (rdata1),
    .rdata2      (rdata2),
    .issue_valid (iv),
    .issue_rd    (issueRd),
    .rs1_pending (rs1P),
    .rs2_pending (rs2P),
    .clr_start   (clrStart),
    .clr_busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        p1;
    logic        p2;
    logic        busy;
  } exp_t;

  exp_t expQ[$];
  exp_t monE;

  int nChecks = 0;
  int nPass   = 0;
  int busyRun = 0;
  int lastRun = 0;

  // Reference model: architectural state only.
  logic [31:0] mRegs [32];
  bit          mPend [32];
  int          clrLeft = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic modelReset();
    for (int i = 0; i < 32; i++) begin
      mRegs[i] = '0;
      mPend[i] = 1'b0;
    end
    clrLeft = 0;
  endtask

  function automatic exp_t predict();
    exp_t e;
    bit   idle;
    idle   = (clrLeft == 0);
    e.busy = !idle;
    e.rd1  = (raddr1 == 0) ? 32'h0 : mRegs[raddr1];
    e.rd2  = (raddr2 == 0) ? 32'h0 : mRegs[raddr2];
    e.p1   = idle && mPend[raddr1];
    e.p2   = idle && mPend[raddr2];
`ifdef REGFILE_BYPASS_EN
    if (rstN && idle && we && waddr != 0 && raddr1 == waddr) begin
      e.rd1 = wdata;
      e.p1  = iv && (issueRd == waddr);
    end
    if (rstN && idle && we && waddr != 0 && raddr2 == waddr) begin
      e.rd2 = wdata;
      e.p2  = iv && (issueRd == waddr);
    end
`endif
    return e;
  endfunction

  task automatic modelUpdate();
    if (clrLeft > 0) begin
      mRegs[32 - clrLeft] = '0;
      clrLeft--;
    end else begin
      if (we && waddr != 0) begin
        mRegs[waddr] = wdata;
        mPend[waddr] = 1'b0;
      end
      if (iv && issueRd != 0) mPend[issueRd] = 1'b1;
      if (clrStart) begin
        for (int i = 0; i < 32; i++) mPend[i] = 1'b0;
        clrLeft = 31;
      end
    end
  endtask

  // One cycle: expectation for the current inputs, then the clock edge.
  task automatic tick();
    if (!rstN) modelReset();
    expQ.push_back(predict());
    @(posedge clk);
    if (rstN) modelUpdate();
    #1;
  endtask

  task automatic quiet();
    we = 1'b0;
    iv = 1'b0;
    clrStart = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1;
    waddr = a;
    wdata = d;
    tick();
    we = 1'b0;
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      monE = expQ.pop_front();
      chk("rdata1", rdata1, monE.rd1);
      chk("rdata2", rdata2, monE.rd2);
      chk("rs1_pending", 32'(rs1P), 32'(monE.p1));
      chk("rs2_pending", 32'(rs2P), 32'(monE.p2));
      chk("clr_busy", 32'(busy), 32'(monE.busy));
    end
    if (busy === 1'b1) busyRun++;
    else if (busyRun > 0) begin
      lastRun = busyRun;
      busyRun = 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, nChecks=%0d", nChecks);
    $fatal(1, "watchdog");
  end

  initial begin
    modelReset();
    @(posedge clk);
    #1;
    tick();
    rstN = 1'b1;
    tick();

    // 1. reset mid-run, x0 stays zero
    wr(5'd7, 32'hA5A5_0707);
    raddr1 = 5'd7;
    tick();
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
    raddr1 = 5'd0;
    wr(5'd0, 32'hDEAD_BEEF);
    tick();

    // 2. write then read, same cycle and next cycle
    raddr1 = 5'd5;
    wr(5'd5, 32'h1234_5678);
    tick();

    // 3. scoreboard set / clear / set-wins
    raddr2 = 5'd3;
    iv = 1'b1; issueRd = 5'd3;
    tick();
    iv = 1'b0;
    tick();
    wr(5'd3, 32'h0000_0333);
    tick();
    iv = 1'b1; issueRd = 5'd3;
    wr(5'd3, 32'h0000_3333);
    iv = 1'b0;
    tick();
    tick();

    // 4. full sweep; write to x9 mid-sweep must be dropped
    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i * 32'h11));
    lastRun = 0;
    clrStart = 1'b1;
    raddr1 = 5'd9;
    tick();
    clrStart = 1'b0;
    for (int c = 0; c < 36; c++) begin
      raddr2 = 5'(c);
      if (c == 5) wr(5'd9, 32'h9999_9999);
      else tick();
    end
    chk("busy_window_sweep", 32'(lastRun), 32'd31);
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i);
      raddr2 = 5'(31 - i);
      tick();
    end

    // 5. clear with a pending bit, second start mid-sweep
    raddr1 = 5'd4;
    iv = 1'b1; issueRd = 5'd4;
    tick();
    iv = 1'b0;
    lastRun = 0;
    clrStart = 1'b1;
    tick();
    clrStart = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    clrStart = 1'b1;
    tick();
    clrStart = 1'b0;
    for (int c = 0; c < 25; c++) tick();
    chk("busy_window_restart", 32'(lastRun), 32'd31);

    // 6. reset in the middle of a sweep
    for (int i = 1; i < 32; i++) wr(5'(i), 32'hC000_0000 | 32'(i));
    clrStart = 1'b1;
    tick();
    clrStart = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    rstN = 1'b0;
    for (int c = 0; c < 4; c++) begin
      raddr1 = 5'(20 + c);
      raddr2 = 5'(c + 1);
      tick();
    end
    rstN = 1'b1;
    raddr1 = 5'd6;
    wr(5'd6, 32'h0606_0606);
    tick();

    // random traffic against the model
    for (int i = 1; i < 32; i++) wr(5'(i), $urandom);
    for (int c = 0; c < 400; c++) begin
      we       = ($urandom_range(1, 0) == 1);
      waddr    = 5'($urandom_range(31, 0));
      wdata    = $urandom;
      iv       = ($urandom_range(2, 0) == 0);
      issueRd  = ($urandom_range(3, 0) == 0) ? waddr : 5'($urandom_range(31, 0));
      raddr1   = ($urandom_range(3, 0) == 0) ? waddr : 5'($urandom_range(31, 0));
      raddr2   = ($urandom_range(3, 0) == 0) ? issueRd : 5'($urandom_range(31, 0));
      clrStart = ($urandom_range(59, 0) == 0);
      tick();
    end
    quiet();
    tick();
    tick();

    for (int w = 0; w < 5 && expQ.size() > 0; w++) @(negedge clk);
    chk("queue_drained", 32'(expQ.size()), 32'd0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
